imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the 16x12 instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs byte pairs into 12-bit instructions.
- It drives the memory write port with sequential addresses from 0, and holds the CPU/PC in stall until loading completes.
- It sits between the host/serial front end and the instruction memory write port.

Parameters:
- ADDR_W, 4, instruction address width
- INSTR_W, 12, instruction width
- DEPTH, 16, number of memory words (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle request to begin a load
- len  input  5  number of words to load, 1..16; sampled on accepted start
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  incoming program byte
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  memory write strobe, one cycle per word
- wr_addr  output  4  memory write address
- wr_data  output  12  instruction to write
- cpu_hold  output  1  stall PC/fetch while loading
- busy  output  1  load in progress
- done  output  1  last load completed successfully; sticky until next accepted start
- word_count  output  5  words written in the current/last load
- err  output  1  sticky: bad len, or nonzero reserved nibble; cleared on accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal low-byte register and counter 0. Takes effect immediately, including mid-load. Words already written stay in memory; no further writes occur.
- States: IDLE, LOW, HIGH, WRITE, DONE.
- IDLE/DONE, start=1:
  - len in 1..16: clear done, err and word_count; latch len; go to LOW; busy=1 and cpu_hold=1 from the next cycle.
  - len=0 or len>16: set err=1; stay in the current state; done unchanged.
- start while busy: ignored, no effect.
- A byte is transferred only when byte_valid && byte_ready.
- byte_ready=1 only in LOW and HIGH. The upstream may hold byte_valid with stable data for any number of cycles.
- LOW: on a transfer, latch byte_data as instr[7:0]; go to HIGH.
- HIGH: on a transfer, form wr_data = {byte_data[3:0], low_byte}. If byte_data[7:4] != 0, set err=1; the word is still written. Go to WRITE.
- WRITE: one cycle. wr_en=1, wr_addr=word_count[3:0], wr_data registered. byte_ready=0.
  - Next cycle word_count increments.
  - If the new count equals len, go to DONE; otherwise go to LOW.
- Latency: high byte accepted in cycle N, so wr_en=1 in cycle N+1. Minimum of 3 cycles per word.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0. Stays in DONE until the next accepted start.
- Outputs when not in WRITE: wr_en=0; wr_addr and wr_data hold their last values.
- Width rules:
  - word_count is 5 bits so that it can represent 16.
  - wr_addr wraps naturally, but it never exceeds len-1 <= 15, so no address wrap occurs within a load.
- Simultaneous events: byte_valid is irrelevant in IDLE/WRITE/DONE; no byte is consumed in those states.

Decomposition:
- Shared package imem_pkg:
  - constants IMEM_ADDR_W=4, IMEM_INSTR_W=12, IMEM_DEPTH=16, INSTR_NOP=12'h000
  - loader state enum (IDLE, LOW, HIGH, WRITE, DONE)
  - the package is reused by instruction_memory and the fetch unit
- Single module: FSM plus counter plus packing register. No sub-module is warranted.

Test Plan:
- Basic load:
  - stimulus: len=4, start, then bytes 20 01 11 02 20 03 00 00 with byte_valid always high
  - response: wr_en pulses at addr 0..3 with data 0x120, 0x211, 0x320, 0x000; word_count=4; done=1; cpu_hold falls the cycle DONE is entered; err=0
- Backpressure/gaps:
  - stimulus: same stream with byte_valid deasserted 3 cycles between every byte
  - response: identical writes; byte_ready=0 during every WRITE cycle; no byte lost or duplicated
- Bad length:
  - stimulus: start with len=0, then start with len=17
  - response: err=1 each time; state remains IDLE; no wr_en; a following len=1 start clears err
- Reserved nibble:
  - stimulus: len=1, bytes AB F5
  - response: wr_data=0x5AB written at addr 0; err=1; done=1
- Reset mid-load:
  - stimulus: len=16; assert rst_n=0 after 2 words
  - response: outputs 0 immediately (asynchronously); a subsequent start with len=2 writes addr 0,1
- Start while busy:
  - stimulus: pulse start with len=3 during a len=2 load
  - response: ignored; load finishes with word_count=2

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and loader state encoding
// for the instruction memory, its loader and the fetch unit.
package imem_pkg;

  localparam int IMEM_ADDR_W  = 4;
  localparam int IMEM_INSTR_W = 12;
  localparam int IMEM_DEPTH   = 16;

  localparam logic [IMEM_INSTR_W-1:0] INSTR_NOP = 12'h000;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOW   = 3'd1,
    LD_HIGH  = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake in, memory
// write port out, bundled as one interface.
interface imem_loader_if;
  import imem_pkg::*;

  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    wr_en;
  logic [IMEM_ADDR_W-1:0]  wr_addr;
  logic [IMEM_INSTR_W-1:0] wr_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs byte pairs into 12-bit words and
// writes them to the instruction memory, stalling the CPU.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = IMEM_INSTR_W,
  parameter int DEPTH   = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  ld_state_e           st_q, st_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic                err_q, err_d;
  logic                len_ok;
  logic [ADDR_W:0]     cnt_inc;

  assign len_ok  = (len != '0) &&
                   (len <= (ADDR_W+1)'(DEPTH));
  assign cnt_inc = cnt_q + 1'b1;

  // next-state, packing and sticky error logic
  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    lo_d   = lo_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    unique case (st_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          if (len_ok) begin
            st_d  = LD_LOW;
            len_d = len;
            cnt_d = '0;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LD_LOW: begin
        if (bus.byte_valid) begin
          lo_d = bus.byte_data;
          st_d = LD_HIGH;
        end
      end
      LD_HIGH: begin
        if (bus.byte_valid) begin
          data_d = {bus.byte_data[3:0], lo_q};
          addr_d = cnt_q[ADDR_W-1:0];
          if (bus.byte_data[7:4] != 4'h0)
            err_d = 1'b1;
          st_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        cnt_d = cnt_inc;
        st_d  = (cnt_inc == len_q) ? LD_DONE : LD_LOW;
      end
      default: st_d = LD_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= LD_IDLE;
      len_q  <= '0;
      cnt_q  <= '0;
      lo_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.byte_ready = (st_q == LD_LOW) ||
                          (st_q == LD_HIGH);
  assign bus.wr_en      = (st_q == LD_WRITE);
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;

  assign busy       = (st_q == LD_LOW)  ||
                      (st_q == LD_HIGH) ||
                      (st_q == LD_WRITE);
  assign cpu_hold   = busy;
  assign done       = (st_q == LD_DONE);
  assign word_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random loads checked
// against a byte-list reference of expected writes.
module tb_imem_loader;
  import imem_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] len;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [4:0] word_count;
  logic       err;

  imem_loader_if bus();

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [7:0]  prog[$];
  logic [15:0] cap[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // capture every memory write; stream must be stalled
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      cap.push_back({bus.wr_addr, bus.wr_data});
      chk("rdy_in_write", 32'(bus.byte_ready), 0);
    end
  end

  task automatic pulse_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = 5'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int to,
                      input int gmin, input int gmax);
    for (int i = from; i < to; i++) begin
      int g;
      int tries;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
      end
      tries = 0;
      forever begin
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = prog[i];
        #1;
        if (bus.byte_ready) break;
        tries++;
        if (tries > 50) begin
          chk("ready_timeout", 0, 1);
          break;
        end
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", 32'(done), 1);
    chk("hold_at_done", 32'(cpu_hold), 0);
    chk("busy_at_done", 32'(busy), 0);
  endtask

  task automatic check_writes(input int n);
    logic err_e;
    logic [15:0] exp;
    err_e = 1'b0;
    chk("n_writes", cap.size(), n);
    for (int i = 0; i < n; i++) begin
      exp = {4'(i), prog[2*i+1][3:0], prog[2*i]};
      if (i < cap.size())
        chk($sformatf("wr%0d", i), 32'(cap[i]), 32'(exp));
      if (prog[2*i+1][7:4] != 4'h0) err_e = 1'b1;
    end
    chk("word_count", 32'(word_count), n);
    chk("err_end", 32'(err), 32'(err_e));
  endtask

  task automatic run_load(input int n,
                          input int gmin, input int gmax);
    cap.delete();
    pulse_start(n);
    chk("busy_start", 32'(busy), 1);
    chk("hold_start", 32'(cpu_hold), 1);
    chk("wc_start", 32'(word_count), 0);
    chk("done_start", 32'(done), 0);
    feed(0, 2*n, gmin, gmax);
    chk("wr_latency", 32'(bus.wr_en), 1);
    wait_done();
    check_writes(n);
  endtask

  task automatic rand_prog(input int n, input int errp);
    prog.delete();
    for (int i = 0; i < n; i++) begin
      logic [3:0] hi;
      hi = ($urandom_range(errp, 0) == 0)
           ? 4'($urandom) : 4'h0;
      prog.push_back(8'($urandom));
      prog.push_back({hi, 4'($urandom)});
    end
  endtask

  initial begin
    int c;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    len    = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_ready", 32'(bus.byte_ready), 0);
    rst_n = 1'b1;

    // bad lengths from IDLE, then a good start clears err
    cap.delete();
    pulse_start(0);
    chk("len0_err", 32'(err), 1);
    chk("len0_busy", 32'(busy), 0);
    pulse_start(17);
    chk("len17_err", 32'(err), 1);
    chk("len17_busy", 32'(busy), 0);
    chk("badlen_nowr", cap.size(), 0);
    prog = '{8'h34, 8'h02};
    run_load(1, 0, 0);

    // basic load, byte_valid always high
    prog = '{8'h20, 8'h01, 8'h11, 8'h02,
             8'h20, 8'h03, 8'h00, 8'h00};
    run_load(4, 0, 0);

    // same stream with 3-cycle gaps
    run_load(4, 3, 3);

    // reserved nibble set
    prog = '{8'hAB, 8'hF5};
    run_load(1, 0, 0);

    // bad length from DONE keeps done
    pulse_start(0);
    chk("done_len0_err", 32'(err), 1);
    chk("done_len0_done", 32'(done), 1);
    chk("done_len0_busy", 32'(busy), 0);

    // random loads
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(16, 1));
      rand_prog(n, 12);
      run_load(n, 0, 2);
    end
    pulse_start(20);
    chk("len20_err", 32'(err), 1);
    chk("len20_done", 32'(done), 1);

    // start while busy is ignored
    rand_prog(2, 1000);
    cap.delete();
    pulse_start(2);
    feed(0, 2, 0, 0);
    pulse_start(3);
    feed(2, 4, 0, 0);
    wait_done();
    check_writes(2);

    // reset in the middle of a 16-word load
    rand_prog(16, 1000);
    cap.delete();
    pulse_start(16);
    feed(0, 4, 0, 0);
    c = 0;
    while (word_count != 5'd2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("mid_wc2", 32'(word_count), 2);
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hold", 32'(cpu_hold), 0);
    chk("arst_wc", 32'(word_count), 0);
    chk("arst_wr_en", 32'(bus.wr_en), 0);
    chk("arst_addr", 32'(bus.wr_addr), 0);
    chk("arst_data", 32'(bus.wr_data), 0);
    chk("arst_ready", 32'(bus.byte_ready), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_prog(2, 4);
    run_load(2, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
